// File: rtl/adder_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_arb_pkg : shared defaults and tag-width helper for adder_arb   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_arb_pkg;

  localparam int unsigned c_DEF_NUM_REQ = 2;
  localparam int unsigned c_DEF_BITS    = 16;
  localparam int unsigned c_DEF_NUM     = 4;
  localparam int unsigned c_DEF_LATENCY = 1;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_arb_tag_fifo : in-order requester-tag FIFO, async reset        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_arb_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned c_AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned c_CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] p);
    return (p == c_AW'(DEPTH-1)) ? '0 : p + c_AW'(1);
  endfunction

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/adder_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_arb : round-robin sharing of one external pipelined adder      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = c_DEF_NUM_REQ,
  parameter int unsigned BITS    = c_DEF_BITS,
  parameter int unsigned NUM     = c_DEF_NUM,
  parameter int unsigned LATENCY = c_DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*NUM*BITS-1:0]   req_data,
  output logic                          add_valid,
  output logic [NUM*BITS-1:0]           add_data,
  input  logic [BITS-1:0]               add_o,
  input  logic                          add_valid_out,
  output logic                          rsp_valid,
  output logic [tag_w(NUM_REQ)-1:0]     rsp_id,
  output logic [BITS-1:0]               rsp_data,
  output logic                          err
);

  localparam int unsigned c_TW    = tag_w(NUM_REQ);
  localparam int unsigned c_DW    = NUM * BITS;
  localparam int unsigned c_DEPTH = LATENCY + 1;
  localparam int unsigned c_CW    = $clog2(c_DEPTH + 1);

  logic [c_TW-1:0] r_rr_ptr;
  logic            r_add_valid;
  logic [c_DW-1:0] r_add_data;
  logic            r_rsp_valid;
  logic [c_TW-1:0] r_rsp_id;
  logic [BITS-1:0] r_rsp_data;
  logic            r_err;

  logic [c_TW:0]   w_sum;
  logic [c_TW-1:0] w_idx;
  logic [c_TW-1:0] w_winner;
  logic [c_TW-1:0] w_next_ptr;
  logic            w_grant;
  logic            w_room;
  logic            w_pop;
  logic            w_stray;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [c_TW-1:0] w_pop_tag;
  logic [c_CW-1:0] w_fifo_count;

  assign w_pop   = add_valid_out && !w_fifo_empty;
  assign w_stray = add_valid_out && (w_fifo_count == '0);
  assign w_room  = !w_fifo_full || w_pop;

  // Search starts at r_rr_ptr; the first valid requester found wins.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_TW+1)'(i);
      if (w_sum >= (c_TW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (c_TW+1)'(NUM_REQ);
      end
      w_idx = w_sum[c_TW-1:0];
      if (!w_grant && req_valid[w_idx]) begin
        w_grant  = 1'b1;
        w_winner = w_idx;
      end
    end
    if (!resetn || !w_room) begin
      w_grant = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  assign w_next_ptr = (w_winner == c_TW'(NUM_REQ-1)) ? '0 : w_winner + c_TW'(1);

  adder_arb_tag_fifo #(
    .DEPTH (c_DEPTH),
    .WIDTH (c_TW)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_grant),
    .i_data  (w_winner),
    .i_pop   (w_pop),
    .o_data  (w_pop_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr    <= '0;
      r_add_valid <= 1'b0;
      r_add_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_add_valid <= w_grant;
      if (w_grant) begin
        r_add_data <= req_data[w_winner*c_DW +: c_DW];
        r_rr_ptr   <= w_next_ptr;
      end
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_id   <= w_pop_tag;
        r_rsp_data <= add_o;
      end
      if (w_stray) begin
        r_err <= 1'b1;
      end
    end
  end

  assign add_valid = r_add_valid;
  assign add_data  = r_add_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one adder (2..8).
REQ-002 Parameter BITS, default 16, operand/result width.
REQ-003 Parameter NUM, default 4, operands per request.
REQ-004 Parameter LATENCY, default 1, adder cycles from valid to valid_out (1..8).
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; at most one bit set per cycle.
REQ-009 req_data  in  NUM_REQ*NUM*BITS  operands; requester r at slice r, operand 0 in low bits.
REQ-010 add_valid  out  1  issue strobe to adder valid.
REQ-011 add_data  out  NUM*BITS  operands to adder data_in.
REQ-012 add_o  in  BITS  adder result o.
REQ-013 add_valid_out  in  1  adder result strobe.
REQ-014 rsp_valid  out  1  result delivered, one cycle pulse.
REQ-015 rsp_id  out  clog2(NUM_REQ)  requester owning rsp_data.
REQ-016 rsp_data  out  BITS  registered copy of add_o.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 Handshake: request r transfers on cycle where req_valid[r] & req_ready[r]; req_data[r] must be stable while req_valid[r] high and unaccepted.
REQ-019 Arbitration: round-robin; search starts at rr_ptr, first valid requester wins; after a grant to r, rr_ptr = (r+1) mod NUM_REQ; no grant, rr_ptr unchanged.
REQ-020 Grant is combinational from req_valid, rr_ptr and tag FIFO state; suppressed when tag FIFO full (count == LATENCY+1).
REQ-021 Issue: on grant, add_valid=1 and add_data=req_data[winner] registered, i.e. appear the cycle after acceptance; add_valid=0 otherwise, add_data holds last value.
REQ-022 On issue, winner index pushed into in-order tag FIFO, depth LATENCY+1.
REQ-023 On add_valid_out=1 with FIFO non-empty: pop tag; next cycle rsp_valid=1, rsp_id=popped tag, rsp_data=add_o.
REQ-024 Total latency accept -> rsp_valid = LATENCY+2 cycles; back-to-back grants sustain one request per cycle.
REQ-025 Simultaneous push and pop in one cycle: both take effect, count unchanged, legal at full (pop frees the slot for the same-cycle push).
REQ-026 add_valid_out=1 with FIFO empty: no pop, rsp_valid stays 0, err set to 1 until reset.
REQ-027 Responses have no backpressure; consumer must accept every rsp_valid pulse.
REQ-028 Result arithmetic is the adder's; block does not modify add_o (wrap mod 2^BITS is the adder's).

Reset
REQ-029 Asynchronous assertion: req_ready, add_valid, rsp_valid, err = 0; add_data, rsp_data, rsp_id = 0; rr_ptr = 0; tag FIFO empty.
REQ-030 Reset mid-operation discards all in-flight tags; results arriving after reset release with empty FIFO set err.
REQ-031 No grants while resetn low; first grant possible on first posedge after release.

Structure
REQ-032 Package adder_arb_pkg holds tag width function (clog2 of NUM_REQ) and default parameter constants.
REQ-033 One sub-module, adder_arb_tag_fifo: synchronous FIFO, parameter depth/width, push/pop/full/empty/count, async active-low reset.
REQ-034 The adder itself is instantiated by the parent, not inside adder_arb.

Verification
REQ-035 Single requester 0 sends {16'h3c5f,16'hfda9,16'he623,16'hf1ca}, LATENCY=1 -> rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=16'h11f5.
REQ-036 Both requesters valid continuously for 4 cycles from reset -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; rsp_data matches model per request.
REQ-037 Requester 1 alone sends {16'hc25c,16'h6b7f,16'h300e,16'hf9c8} -> rsp_id=1, rsp_data=16'h57b1.
REQ-038 Adder model stalls valid_out for 3 cycles with LATENCY=1 -> after 2 issues req_ready all 0 until a pop; pop+push same cycle keeps throughput; no lost or reordered tags.
REQ-039 Inject add_valid_out with nothing issued -> err=1 next cycle, rsp_valid=0; err stays 1 until resetn low.
REQ-040 Assert resetn low with 2 requests in flight -> all outputs 0 immediately; after release, new request {16'h0e83,16'hc795,16'hdd93,16'h0114} -> rsp_data=16'hb4bf, rsp_id correct.
